// File: rtl/stack_frame_pkg.sv
// stack_frame_pkg: shared encodings for the call-frame controller.
// Holds request commands, error codes, stack op/status codes and FSM states.
package stack_frame_pkg;

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_PUSH    = 3'd1;
    localparam logic [2:0] CMD_POP     = 3'd2;
    localparam logic [2:0] CMD_REPLACE = 3'd3;
    localparam logic [2:0] CMD_CALL    = 3'd4;
    localparam logic [2:0] CMD_RETURN  = 3'd5;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_STACK     = 3'd1;
    localparam logic [2:0] ERR_ARGS      = 3'd2;
    localparam logic [2:0] ERR_FRAME_OVF = 3'd3;
    localparam logic [2:0] ERR_FRAME_UDF = 3'd4;

    localparam logic [2:0] STK_NONE            = 3'd0;
    localparam logic [2:0] STK_PUSH            = 3'd1;
    localparam logic [2:0] STK_POP             = 3'd2;
    localparam logic [2:0] STK_REPLACE         = 3'd3;
    localparam logic [2:0] STK_UNDERFLOW_RESET = 3'd4;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_EMPTY     = 3'd1;
    localparam logic [2:0] ST_FULL      = 3'd2;
    localparam logic [2:0] ST_OVERFLOW  = 3'd3;
    localparam logic [2:0] ST_UNDERFLOW = 3'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_R_SAVE    = 3'd1;
    localparam logic [2:0] S_R_DROP    = 3'd2;
    localparam logic [2:0] S_R_RESTORE = 3'd3;
    localparam logic [2:0] S_R_PUSH    = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_C_LOCALS  = 3'd6;

    function automatic logic is_stk_err(input logic [2:0] st);
        return (st == ST_OVERFLOW) || (st == ST_UNDERFLOW);
    endfunction

endpackage

// File: rtl/frame_lifo.sv
// frame_lifo: small LIFO of saved frame bases (2^AW entries of W bits).
// Ports: clk/rst; push_i/data_i write; pop_i drops top_o; count_o, full_o, empty_o.
module frame_lifo #(
    parameter int W  = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  top_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int N = 1 << AW;

    logic [W-1:0] mem_q [N];
    logic [AW:0]  cnt_q;
    logic [AW:0]  cnt_d;
    logic [AW:0]  tidx;

    // Count never exceeds N, so the MSB alone flags full.
    assign full_o  = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign tidx    = cnt_q - (AW+1)'(1);
    assign top_o   = empty_o ? '0 : mem_q[tidx[AW-1:0]];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = tidx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[cnt_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: call-frame sequencer in front of an operand stack.
// Build option: define STACK_FRAME_LOCALS_EN so CALL also pushes zeroed locals.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_cmd/req_data
//   request; resp_valid/resp_err/resp_status completion; stk_op/stk_data/
//   stk_underflow_limit drive the stack; stk_index/stk_tos/stk_status observe
//   it; frame_depth counts saved frames.
module stack_frame_ctrl
    import stack_frame_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter int FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    output logic [2:0]       resp_err,
    output logic [2:0]       resp_status,
    output logic [2:0]       stk_op,
    output logic [WIDTH-1:0] stk_data,
    output logic [DEPTH:0]   stk_underflow_limit,
    input  logic [DEPTH:0]   stk_index,
    input  logic [WIDTH-1:0] stk_tos,
    input  logic [2:0]       stk_status,
    output logic [FRAMES:0]  frame_depth
);

    logic [2:0]       state_q, state_d;
    logic [DEPTH:0]   lim_q, lim_d;
    logic             res_q, res_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [2:0]       err_q, err_d;
    logic             chk_q, chk_d;
    logic             rv_q, rv_d;

    logic             f_push, f_pop, f_full, f_empty;
    logic [DEPTH:0]   f_top;

    logic [DEPTH:0]   avail;
    logic [31:0]      args32;
    logic             stk_now;
    logic [2:0]       err_acc;

`ifdef STACK_FRAME_LOCALS_EN
    localparam int HW = WIDTH / 2;
    logic [HW-1:0]    loc_q, loc_d;
    logic [HW-1:0]    locs;
    assign locs   = req_data[WIDTH-1:HW];
    assign args32 = 32'(req_data[HW-1:0]);
`else
    assign args32 = 32'(req_data);
`endif

    frame_lifo #(
        .W  (DEPTH + 1),
        .AW (FRAMES)
    ) u_lifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .data_i  (lim_q),
        .top_o   (f_top),
        .count_o (frame_depth),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    assign avail = stk_index - lim_q;

    // Status is only meaningful the cycle after we issued a stack op.
    assign stk_now = chk_q && is_stk_err(stk_status);
    // First error of a transaction wins; ERR_STACK is sticky.
    assign err_acc = (err_q != ERR_NONE) ? err_q :
                     (stk_now ? ERR_STACK : ERR_NONE);

    assign req_ready           = (state_q == S_IDLE);
    assign resp_valid          = rv_q || (state_q == S_DONE);
    assign resp_err            = resp_valid ? err_acc : ERR_NONE;
    assign resp_status         = resp_valid ? stk_status : ST_OK;
    assign stk_underflow_limit = lim_q;

    always_comb begin
        state_d  = state_q;
        lim_d    = lim_q;
        res_d    = res_q;
        tos_d    = tos_q;
        err_d    = err_acc;
        chk_d    = 1'b0;
        rv_d     = 1'b0;
        stk_op   = STK_NONE;
        stk_data = '0;
        f_push   = 1'b0;
        f_pop    = 1'b0;
`ifdef STACK_FRAME_LOCALS_EN
        loc_d    = loc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d = ERR_NONE;
                    unique case (req_cmd)
                        CMD_PUSH, CMD_POP, CMD_REPLACE: begin
                            unique case (req_cmd)
                                CMD_PUSH: stk_op = STK_PUSH;
                                CMD_POP:  stk_op = STK_POP;
                                default:  stk_op = STK_REPLACE;
                            endcase
                            stk_data = req_data;
                            chk_d    = 1'b1;
                            rv_d     = 1'b1;
                        end
                        CMD_CALL: begin
                            rv_d = 1'b1;
                            if (f_full) begin
                                err_d = ERR_FRAME_OVF;
                            end else if (args32 > 32'(avail)) begin
                                err_d = ERR_ARGS;
                            end else begin
                                f_push = 1'b1;
                                lim_d  = stk_index - args32[DEPTH:0];
`ifdef STACK_FRAME_LOCALS_EN
                                if (locs != '0) begin
                                    rv_d    = 1'b0;
                                    loc_d   = locs;
                                    state_d = S_C_LOCALS;
                                end
`endif
                            end
                        end
                        CMD_RETURN: begin
                            if (f_empty) begin
                                err_d = ERR_FRAME_UDF;
                                rv_d  = 1'b1;
                            end else if ((req_data != '0) &&
                                         (stk_index == lim_q)) begin
                                err_d = ERR_ARGS;
                                rv_d  = 1'b1;
                            end else begin
                                res_d   = (req_data != '0);
                                state_d = S_R_SAVE;
                            end
                        end
                        default: begin
                            rv_d = 1'b1;
                        end
                    endcase
                end
            end
            S_R_SAVE: begin
                tos_d   = stk_tos;
                state_d = S_R_DROP;
            end
            S_R_DROP: begin
                stk_op  = STK_UNDERFLOW_RESET;
                chk_d   = 1'b1;
                state_d = S_R_RESTORE;
            end
            S_R_RESTORE: begin
                f_pop   = 1'b1;
                lim_d   = f_top;
                state_d = res_q ? S_R_PUSH : S_DONE;
            end
            S_R_PUSH: begin
                stk_op   = STK_PUSH;
                stk_data = tos_q;
                chk_d    = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef STACK_FRAME_LOCALS_EN
            S_C_LOCALS: begin
                stk_op = STK_PUSH;
                chk_d  = 1'b1;
                loc_d  = loc_q - HW'(1);
                if (loc_q == HW'(1)) begin
                    rv_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            res_q   <= 1'b0;
            tos_q   <= '0;
            err_q   <= ERR_NONE;
            chk_q   <= 1'b0;
            rv_q    <= 1'b0;
`ifdef STACK_FRAME_LOCALS_EN
            loc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            res_q   <= res_d;
            tos_q   <= tos_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            rv_q    <= rv_d;
`ifdef STACK_FRAME_LOCALS_EN
            loc_q   <= loc_d;
`endif
        end
    end

endmodule

// File: doc/stack_frame_ctrl.md
Name: stack_frame_ctrl

Overview:
- Call-frame controller placed between the instruction decoder and the operand-stack instance (stack.vh op/status encoding).
- Forwards plain stack ops from a single requester.
- Sequences CALL/RETURN by driving the stack's op, data and underflow_limit, keeping saved frame bases in an internal LIFO.
- RETURN drops the callee frame and carries back at most one result value.

Parameters:
- WIDTH, 8, data word width; must match the stack instance.
- DEPTH, 3, stack depth exponent; index and limit are DEPTH+1 bits.
- FRAMES, 2, frame-LIFO depth exponent; holds 2^FRAMES saved limits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (1 only in IDLE)
- req_cmd  in  3  CMD_NONE/PUSH/POP/REPLACE/CALL/RETURN (package encoding)
- req_data  in  WIDTH  PUSH/REPLACE value; CALL: argument count; RETURN: result count (0 or 1)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  3  ERR_* code, valid with resp_valid
- resp_status  out  3  stack status sampled at completion
- stk_op  out  3  stack op (stack.vh)
- stk_data  out  WIDTH  stack data
- stk_underflow_limit  out  DEPTH+1  current frame base (registered)
- stk_index  in  DEPTH+1  stack index
- stk_tos  in  WIDTH  stack top
- stk_status  in  3  stack status
- frame_depth  out  FRAMES+1  number of saved frames

Behaviour:
- Reset (asynchronous): state=IDLE, stk_underflow_limit=0, frame_depth=0, resp_valid=0, resp_err=ERR_NONE, stk_op=NONE, saved result cleared.
- stk_op and stk_data decode combinationally from state and request.
- Handshake: a request is accepted on a clk edge where req_valid&&req_ready. In IDLE with no request, stk_op=NONE.
- Pass-through (PUSH/POP/REPLACE/NONE):
  - stk_op = op, stk_data = req_data in the accept cycle.
  - resp_valid is asserted the next cycle with resp_status = stk_status.
  - resp_err = ERR_STACK if status is OVERFLOW or UNDERFLOW, else ERR_NONE.
  - Back-to-back accepts are allowed.
- CALL (accept cycle, stk_op=NONE):
  - If frame LIFO is full -> ERR_FRAME_OVF.
  - Else if req_data > stk_index - stk_underflow_limit -> ERR_ARGS.
  - Else push the old limit, limit := stk_index - req_data, frame_depth++.
  - resp_valid next cycle. On error, no state changes.
- RETURN FSM: IDLE -> R_SAVE -> R_DROP -> R_RESTORE -> R_PUSH -> DONE -> IDLE.
  - Accept: if frame_depth==0 -> ERR_FRAME_UDF, respond next cycle, no stack op.
  - Accept: if result count==1 and stk_index==limit -> ERR_ARGS.
  - R_SAVE: latch stk_tos.
  - R_DROP: stk_op=UNDERFLOW_RESET (index := limit).
  - R_RESTORE: pop LIFO into limit, frame_depth--.
  - R_PUSH: only if result count==1; stk_op=PUSH, stk_data=latched value. Otherwise skip to DONE.
  - DONE: resp_valid=1.
  - Latency: 5 cycles accept-to-resp with a result, 4 without.
  - Result count >1 is treated as 1.
- Any stk_status OVERFLOW/UNDERFLOW in the cycle after a controller-issued op sets a sticky ERR_STACK for that response; the sequence still completes.
- Stack index width arithmetic is unsigned DEPTH+1 bits; no wrap checks beyond the above.
- Reset mid-sequence aborts immediately to the reset state; no response is produced.

Optional Feature:
- Macro STACK_FRAME_LOCALS_EN.
- Enabled:
  - CALL takes req_data[WIDTH-1:WIDTH/2] as the locals count L and req_data[WIDTH/2-1:0] as the argument count.
  - After the limit update, state C_LOCALS issues L cycles of PUSH 0, using a down-counter.
  - resp_valid follows the last push, i.e. L+1 cycles after accept.
  - Overflow during locals -> ERR_STACK; remaining pushes are still issued.
- Disabled: all of req_data is the argument count; CALL always responds after 1 cycle.

Decomposition:
- Package stack_frame_pkg: CMD_* encodings, ERR_NONE/ERR_STACK/ERR_ARGS/ERR_FRAME_OVF/ERR_FRAME_UDF, and state encodings.
- Reuse stack.vh for stack ops and status.
- One sub-module, frame_lifo: a width DEPTH+1, 2^FRAMES deep LIFO with push/pop/count.

Test Plan:
- Test configuration: DEPTH=3, FRAMES=2; each scenario lists stimulus -> required response.
- PUSH 1,2,3 then CALL args=2 -> ERR_NONE, stk_underflow_limit=1, frame_depth=1; POP x3 -> third response ERR_STACK, status UNDERFLOW.
- CALL args=2 (from previous), PUSH 7, RETURN results=1 -> resp after 5 cycles, ERR_NONE, limit=0, stk_index=2, stk_tos=7.
- RETURN with frame_depth=0 -> ERR_FRAME_UDF, stk_op stays NONE, limit unchanged.
- Five CALLs args=0 -> fifth returns ERR_FRAME_OVF, frame_depth=4.
- CALL args=5 with index=3, limit=0 -> ERR_ARGS; reset asserted in R_DROP of a RETURN -> limit=0, frame_depth=0, no resp_valid.
- With STACK_FRAME_LOCALS_EN: index=1, CALL req_data=8'h21 -> limit=0, two PUSH 0 issued, stk_index=3, resp 3 cycles after accept.
